// File: rtl/nios_dbg_pkg.sv
// Shared types and jdo field positions for the Nios debug on-chip memory controller.
package nios_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    JRD  = 2'd1,
    CRD  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CMD_A  = 2'd0,
    CMD_NA = 2'd1,
    CMD_B  = 2'd2
  } cmd_e;

  localparam int RD_EN_BIT = 35;
  localparam int WDATA_HI  = 34;
  localparam int WDATA_LO  = 3;
  localparam int ADDR_LO   = 2;

  // Width of the jdo slice kept for a queued command (rd_en down to address LSB).
  localparam int CMD_FW = RD_EN_BIT - ADDR_LO + 1;

endpackage

// File: rtl/nios_dbg_ocimem_ctrl.sv
// Executes JTAG debug RAM reads/writes and arbitrates CPU Avalon access to the
// same single-port RAM, JTAG first. Current state and jaddr are exposed on dbg_*.
module nios_dbg_ocimem_ctrl
  import nios_dbg_pkg::*;
#(
  parameter int          ADDR_W      = 8,
  parameter logic [31:0] MONDREG_RST = 32'h0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              jtag_busy,
  output logic              jtag_overrun,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [3:0]        ram_byteen,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output state_e            dbg_state,
  output logic [ADDR_W-1:0] dbg_jaddr
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   jaddr_q, jaddr_d;
  logic [31:0]         mon_q, mon_d;
  logic                overrun_q, overrun_d;
  logic                pend_valid_q, pend_valid_d;
  cmd_e                pend_kind_q, pend_kind_d;
  logic [CMD_FW-1:0]   pend_f_q, pend_f_d;

  logic                take_any;
  cmd_e                strobe_kind;
  cmd_e                cmd_kind;
  logic [CMD_FW-1:0]   cmd_f;
  logic                cmd_rd;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [31:0]         cmd_wdata;
  logic                unused_jdo;

  assign unused_jdo  = ^{jdo[37:RD_EN_BIT+1], jdo[ADDR_LO-1:0]};
  assign take_any    = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign strobe_kind = take_action_ocimem_b    ? CMD_B  :
                       take_no_action_ocimem_a ? CMD_NA : CMD_A;

  // A queued command always runs before a fresh strobe.
  assign cmd_kind  = pend_valid_q ? pend_kind_q : strobe_kind;
  assign cmd_f     = pend_valid_q ? pend_f_q : jdo[RD_EN_BIT:ADDR_LO];
  assign cmd_rd    = cmd_f[CMD_FW-1];
  assign cmd_addr  = cmd_f[ADDR_W-1:0];
  assign cmd_wdata = cmd_f[WDATA_HI-ADDR_LO:WDATA_LO-ADDR_LO];

  always_comb begin
    state_d         = state_q;
    jaddr_d         = jaddr_q;
    mon_d           = mon_q;
    overrun_d       = overrun_q;
    pend_valid_d    = pend_valid_q;
    pend_kind_d     = pend_kind_q;
    pend_f_d        = pend_f_q;
    ram_addr        = cpu_address;
    ram_wren        = 1'b0;
    ram_byteen      = cpu_byteenable;
    ram_wdata       = cpu_writedata;
    cpu_waitrequest = cpu_read | cpu_write;
    cpu_readdata    = '0;

    // Strobes that cannot run now are queued once; further ones are lost.
    if (take_any) begin
      if (pend_valid_q) begin
        overrun_d = 1'b1;
      end else if (state_q != IDLE) begin
        pend_valid_d = 1'b1;
        pend_kind_d  = strobe_kind;
        pend_f_d     = jdo[RD_EN_BIT:ADDR_LO];
      end
    end

    case (state_q)
      IDLE: begin
        if (pend_valid_q || take_any) begin
          pend_valid_d = 1'b0;
          case (cmd_kind)
            CMD_A: begin
              if (cmd_rd) begin
                ram_addr = cmd_addr;
                jaddr_d  = cmd_addr + ADDR_W'(1);
                state_d  = JRD;
              end else begin
                jaddr_d = cmd_addr;
              end
            end
            CMD_NA: begin
              ram_addr = jaddr_q;
              jaddr_d  = jaddr_q + ADDR_W'(1);
              state_d  = JRD;
            end
            CMD_B: begin
              ram_wren   = 1'b1;
              ram_addr   = jaddr_q;
              ram_wdata  = cmd_wdata;
              ram_byteen = 4'hF;
              jaddr_d    = jaddr_q + ADDR_W'(1);
            end
            default: ;
          endcase
        end else if (cpu_write) begin
          ram_wren        = 1'b1;
          cpu_waitrequest = 1'b0;
        end else if (cpu_read) begin
          state_d = CRD;
        end
      end
      JRD: begin
        mon_d   = ram_rdata;
        state_d = IDLE;
      end
      CRD: begin
        cpu_readdata    = ram_rdata;
        cpu_waitrequest = 1'b0;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!reset_n) begin
      ram_wren        = 1'b0;
      cpu_waitrequest = cpu_read | cpu_write;
      cpu_readdata    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      jaddr_q      <= '0;
      mon_q        <= MONDREG_RST;
      overrun_q    <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_kind_q  <= CMD_A;
      pend_f_q     <= '0;
    end else begin
      state_q      <= state_d;
      jaddr_q      <= jaddr_d;
      mon_q        <= mon_d;
      overrun_q    <= overrun_d;
      pend_valid_q <= pend_valid_d;
      pend_kind_q  <= pend_kind_d;
      pend_f_q     <= pend_f_d;
    end
  end

  assign MonDReg      = mon_q;
  assign jtag_busy    = (state_q == JRD) | pend_valid_q;
  assign jtag_overrun = overrun_q;
  assign dbg_state    = state_q;
  assign dbg_jaddr    = jaddr_q;

endmodule

// File: tb/tb_nios_dbg_ocimem_ctrl.sv
// Directed bench for nios_dbg_ocimem_ctrl with a behavioural 1-cycle-latency RAM.
module tb_nios_dbg_ocimem_ctrl;
  import nios_dbg_pkg::*;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [37:0]       jdo;
  logic              take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [31:0]       MonDReg;
  logic              jtag_busy, jtag_overrun;
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_read, cpu_write;
  logic [31:0]       cpu_writedata;
  logic [3:0]        cpu_byteenable;
  logic [31:0]       cpu_readdata;
  logic              cpu_waitrequest;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wren;
  logic [3:0]        ram_byteen;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  state_e            dbg_state;
  logic [ADDR_W-1:0] dbg_jaddr;

  logic [31:0] mem [0:255];
  logic [31:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  // clock / reset
  always #5 clk = ~clk;

  nios_dbg_ocimem_ctrl #(.ADDR_W(ADDR_W), .MONDREG_RST(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .MonDReg(MonDReg), .jtag_busy(jtag_busy), .jtag_overrun(jtag_overrun),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
    .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_byteen(ram_byteen),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .dbg_state(dbg_state), .dbg_jaddr(dbg_jaddr)
  );

  // RAM model: byte-enabled write, registered read
  always @(posedge clk) begin
    logic [31:0] w;
    w = mem[ram_addr];
    if (ram_wren) begin
      for (int i = 0; i < 4; i++)
        if (ram_byteen[i]) w[i*8 +: 8] = ram_wdata[i*8 +: 8];
      mem[ram_addr] <= w;
    end
    ram_rdata <= mem[ram_addr];
  end

  always @(posedge clk) begin
    if (reset_n && (int'(take_action_ocimem_a) + int'(take_no_action_ocimem_a)
                    + int'(take_action_ocimem_b)) > 1)
      $error("more than one take_* strobe in one cycle");
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_mon(input string tag);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
    check(tag, MonDReg, e);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_a(input logic rd, input logic [ADDR_W-1:0] addr);
    jdo = '0;
    jdo[RD_EN_BIT] = rd;
    jdo[ADDR_W+ADDR_LO-1:ADDR_LO] = addr;
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
  endtask

  task automatic strobe_na();
    jdo = '0;
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic strobe_b(input logic [31:0] data);
    jdo = '0;
    jdo[WDATA_HI:WDATA_LO] = data;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {4{i[7:0]}};
    mem[8'h10] = 32'hDEADBEEF;
    ram_rdata = '0;
    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 0; take_no_action_ocimem_a = 0; take_action_ocimem_b = 0;
    cpu_address = 8'h05; cpu_read = 0; cpu_write = 1'b1;
    cpu_writedata = 32'hFFFF_FFFF; cpu_byteenable = 4'hF;

    // reset: no RAM write, request held off
    repeat (2) tick();
    @(negedge clk);
    check("rst_wren", 32'(ram_wren), 32'd0);
    check("rst_waitreq", 32'(cpu_waitrequest), 32'd1);
    tick();
    cpu_write = 1'b0;
    reset_n = 1'b1;
    tick();
    check("rst_mon", MonDReg, 32'h0);
    check("rst_busy", 32'(jtag_busy), 32'd0);
    check("rst_overrun", 32'(jtag_overrun), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_jaddr", 32'(dbg_jaddr), 32'h0);
    check("rst_mem5", mem[8'h05], 32'h05050505);

    // ocimem_a read at 0x10
    exp_q.push_back(32'hDEADBEEF);
    strobe_a(1'b1, 8'h10);
    check("t1_state_jrd", 32'(dbg_state), 32'(JRD));
    check("t1_busy", 32'(jtag_busy), 32'd1);
    check("t1_mon_early", MonDReg, 32'h0);
    tick();
    check_mon("t1_mon");
    check("t1_jaddr", 32'(dbg_jaddr), 32'h11);
    check("t1_state_idle", 32'(dbg_state), 32'(IDLE));

    // address load then two writes, wrapping 0xFF -> 0x00
    strobe_a(1'b0, 8'hFF);
    check("t2_jaddr_ld", 32'(dbg_jaddr), 32'hFF);
    check("t2_state", 32'(dbg_state), 32'(IDLE));
    strobe_b(32'h12345678);
    strobe_b(32'hCAFEF00D);
    check("t2_mem_ff", mem[8'hFF], 32'h12345678);
    check("t2_mem_00", mem[8'h00], 32'hCAFEF00D);
    check("t2_jaddr_wrap", 32'(dbg_jaddr), 32'h01);
    check("t2_mon_keep", MonDReg, 32'hDEADBEEF);

    // CPU read collides with a JTAG strobe
    cpu_read = 1'b1; cpu_address = 8'h20;
    take_no_action_ocimem_a = 1'b1;
    @(negedge clk);
    check("t3_wait_c0", 32'(cpu_waitrequest), 32'd1);
    check("t3_addr_c0", 32'(ram_addr), 32'h01);
    tick();
    take_no_action_ocimem_a = 1'b0;
    @(negedge clk);
    check("t3_wait_jrd", 32'(cpu_waitrequest), 32'd1);
    check("t3_state_jrd", 32'(dbg_state), 32'(JRD));
    tick();
    exp_q.push_back(32'h01010101);
    check_mon("t3_mon");
    @(negedge clk);
    check("t3_wait_idle", 32'(cpu_waitrequest), 32'd1);
    check("t3_addr_cpu", 32'(ram_addr), 32'h20);
    tick();
    @(negedge clk);
    check("t3_wait_crd", 32'(cpu_waitrequest), 32'd0);
    check("t3_rdata", cpu_readdata, 32'h20202020);
    tick();
    cpu_read = 1'b0;
    check("t3_state_end", 32'(dbg_state), 32'(IDLE));
    check("t3_jaddr", 32'(dbg_jaddr), 32'h02);

    // back-to-back strobes: one queued, one dropped
    strobe_na();
    strobe_na();
    exp_q.push_back(32'h02020202);
    check_mon("t4_mon_first");
    check("t4_busy_pend", 32'(jtag_busy), 32'd1);
    check("t4_overrun_pre", 32'(jtag_overrun), 32'd0);
    strobe_b(32'h99999999);
    check("t4_overrun", 32'(jtag_overrun), 32'd1);
    check("t4_state_jrd", 32'(dbg_state), 32'(JRD));
    tick();
    exp_q.push_back(32'h03030303);
    check_mon("t4_mon_second");
    check("t4_jaddr", 32'(dbg_jaddr), 32'h04);
    check("t4_mem4", mem[8'h04], 32'h04040404);
    check("t4_busy_end", 32'(jtag_busy), 32'd0);
    tick();
    check("t4_overrun_sticky", 32'(jtag_overrun), 32'd1);

    // reset during JRD, with a write strobe in the reset cycle
    strobe_na();
    check("t5_state_jrd", 32'(dbg_state), 32'(JRD));
    reset_n = 1'b0;
    take_action_ocimem_b = 1'b1;
    jdo = '0;
    jdo[WDATA_HI:WDATA_LO] = 32'h77777777;
    @(negedge clk);
    check("t5_rst_wren", 32'(ram_wren), 32'd0);
    tick();
    take_action_ocimem_b = 1'b0;
    reset_n = 1'b1;
    check("t5_mon", MonDReg, 32'h0);
    check("t5_jaddr", 32'(dbg_jaddr), 32'h0);
    check("t5_state", 32'(dbg_state), 32'(IDLE));
    check("t5_overrun", 32'(jtag_overrun), 32'd0);
    check("t5_busy", 32'(jtag_busy), 32'd0);
    check("t5_mem0", mem[8'h00], 32'hCAFEF00D);

    // single-cycle CPU write with partial byte enables
    cpu_write = 1'b1; cpu_address = 8'h05;
    cpu_writedata = 32'hA5A5A5A5; cpu_byteenable = 4'b0011;
    @(negedge clk);
    check("t5_cpu_wait", 32'(cpu_waitrequest), 32'd0);
    check("t5_cpu_wren", 32'(ram_wren), 32'd1);
    tick();
    cpu_write = 1'b0;
    check("t5_mem5", mem[8'h05], 32'h0505A5A5);
    check("t5_state_end", 32'(dbg_state), 32'(IDLE));

    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
